// File: rtl/clock_4mhz.sv
// ---------------------------------------------------------------------------
// clock_4mhz : divides clk_in by DIV into a glitch-free registered clock.
// Optional 50 % duty stage for odd DIV when CLOCK_4MHZ_DUTY50_EN is defined.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clock_4mhz #(
  parameter int DIV = 3
) (
  input  logic clk_in,
  input  logic reset,
  output logic clk_4mhz
);

  localparam int CW = $clog2(DIV);
  localparam int H  = DIV / 2;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] C_HIGH = CW'(H);

  if (DIV < 2 || DIV > 16) begin : g_div_check
    $error("clock_4mhz: DIV must be in 2..16");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          q_p;
  logic          q_p_next;

  always_comb begin
    cnt_next = (cnt == C_LAST) ? '0 : cnt + 1'b1;
    q_p_next = (cnt_next != '0) && (cnt_next <= C_HIGH);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      q_p <= 1'b0;
    end else begin
      cnt <= cnt_next;
      q_p <= q_p_next;
    end
  end

`ifdef CLOCK_4MHZ_DUTY50_EN
  logic q_n;

  if (DIV % 2 == 1) begin : g_duty_odd
    // q_n is still high when q_p falls, stretching high by half a cycle.
    always_ff @(negedge clk_in or posedge reset) begin
      if (reset) q_n <= 1'b0;
      else       q_n <= q_p;
    end
  end else begin : g_duty_even
    assign q_n = 1'b0;
  end

  assign clk_4mhz = q_p | q_n;
`else
  assign clk_4mhz = q_p;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clock_4mhz.sv
// Directed bench for clock_4mhz at DIV=3, 4 and 5, with or without the duty macro.
`default_nettype none
`timescale 1ns/100ps

module tb_clock_4mhz;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  logic out3, out4, out5;
  int   vectors = 0;
  int   errors  = 0;

  clock_4mhz #(.DIV(3)) dut3 (.clk_in(clk_in), .reset(reset), .clk_4mhz(out3));
  clock_4mhz #(.DIV(4)) dut4 (.clk_in(clk_in), .reset(reset), .clk_4mhz(out4));
  clock_4mhz #(.DIV(5)) dut5 (.clk_in(clk_in), .reset(reset), .clk_4mhz(out5));

  always #41.6 clk_in = ~clk_in;

  // Expected samples after release, in time order: pos1,neg1,pos2,neg2,...,pos6,neg6.
`ifdef CLOCK_4MHZ_DUTY50_EN
  localparam logic [11:0] EXP3 = 12'b111000_111000;
  localparam logic [11:0] EXP5 = 12'b111110_000011;
`else
  localparam logic [11:0] EXP3 = 12'b110000_110000;
  localparam logic [11:0] EXP5 = 12'b111100_000011;
`endif
  localparam logic [11:0] EXP4 = 12'b111100_001111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_low(input string tag);
    chk({tag, "_d3"}, {31'd0, out3}, 32'd0);
    chk({tag, "_d4"}, {31'd0, out4}, 32'd0);
    chk({tag, "_d5"}, {31'd0, out5}, 32'd0);
  endtask

  task automatic check_seq(input string tag);
    logic [11:0] e3, e4, e5;
    e3 = EXP3; e4 = EXP4; e5 = EXP5;
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) @(posedge clk_in);
      else            @(negedge clk_in);
      #1;
      chk($sformatf("%s_d3_s%0d", tag, k), {31'd0, out3}, {31'd0, e3[11-k]});
      chk($sformatf("%s_d4_s%0d", tag, k), {31'd0, out4}, {31'd0, e4[11-k]});
      chk($sformatf("%s_d5_s%0d", tag, k), {31'd0, out5}, {31'd0, e5[11-k]});
    end
  endtask

  task automatic release_reset();
    @(negedge clk_in);
    #1 reset = 1'b0;
  endtask

  initial begin
    int   rises;
    int   last_rise;
    logic prev;

    #1 check_all_low("reset_t0");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in); #1;
      check_all_low("in_reset");
      @(posedge clk_in); #1;
      check_all_low("in_reset_pos");
    end

    release_reset();
    check_seq("startup");

    // Seventh edge: cnt=1 on dut3 and cnt=2 on dut5, both outputs high.
    @(posedge clk_in); #5;
    chk("pre_reset_d3_high", {31'd0, out3}, 32'd1);
    chk("pre_reset_d5_high", {31'd0, out5}, 32'd1);
    reset = 1'b1;
    #0.1 check_all_low("async_assert");
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_in); #1;
      check_all_low("reset_hold");
    end
    release_reset();
    check_seq("after_reset");

    // Long run of roughly 400 us on dut3.
    reset = 1'b1;
    #10 release_reset();
    rises     = 0;
    last_rise = -1;
    prev      = 1'b0;
    for (int k = 1; k <= 4800; k++) begin
      @(posedge clk_in); #1;
      if (out3 && !prev) begin
        rises++;
        if (last_rise >= 0) chk("period_cycles", k - last_rise, 32'd3);
        else                chk("first_rise_edge", k, 32'd1);
        last_rise = k;
      end
      prev = out3;
    end
    chk("rise_count", rises, 32'd1600);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
